// File: rtl/tap_window_feeder_if.sv
// Sample stream, mu configuration and window outputs of tap_window_feeder.
// master drives samples/mu; slave is the feeder itself.
interface tap_window_feeder_if #(
    parameter int unsigned DATA_W = 16
);
    logic signed [DATA_W-1:0] s_data;
    logic                     s_valid;
    logic                     s_last;
    logic                     s_ready;
    logic signed [DATA_W-1:0] mu_cfg;
    logic                     mu_load;
    logic signed [DATA_W-1:0] data1_out;
    logic signed [DATA_W-1:0] data2_out;
    logic signed [DATA_W-1:0] data3_out;
    logic signed [DATA_W-1:0] data4_out;
    logic signed [DATA_W-1:0] mu_out;
    logic                     enable_out;
    logic                     frame_done;

    modport master (
        output s_data, s_valid, s_last, mu_cfg, mu_load,
        input  s_ready, data1_out, data2_out, data3_out, data4_out,
        input  mu_out, enable_out, frame_done
    );

    modport slave (
        input  s_data, s_valid, s_last, mu_cfg, mu_load,
        output s_ready, data1_out, data2_out, data3_out, data4_out,
        output mu_out, enable_out, frame_done
    );
endinterface

// File: rtl/tap_window_feeder.sv
// Keeps a 4-deep window of Q2.14 samples and strobes it, with a frame-stable mu,
// to the weighted-sum stage; frames are optionally drained with zero pads.
module tap_window_feeder #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MODE_BLOCK = 0,
    parameter int unsigned FLUSH_EN   = 1
) (
    input logic               clk,
    input logic               rst,
    tap_window_feeder_if.slave bus
);

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam logic signed [DATA_W-1:0] MU_ONE = {2'b01, {(DATA_W-2){1'b0}}};

    state_t state_q, state_d;

    // w_q[0] is the newest sample, w_q[3] the oldest
    logic signed [DATA_W-1:0] w_q [4];
    logic signed [DATA_W-1:0] w_d [4];
    logic        [2:0]        fill_q, fill_d;
    logic        [1:0]        grp_q, grp_d;
    logic        [1:0]        pad_q, pad_d;

    logic signed [DATA_W-1:0] out_q [4];
    logic signed [DATA_W-1:0] mu_sh_q;
    logic signed [DATA_W-1:0] mu_q;
    logic                     en_q;
    logic                     done_q;

    logic ready;
    logic accept;
    logic first_acc;
    logic emit;

    always_comb begin
        ready     = !rst && (state_q == FILL || state_q == RUN);
        accept    = bus.s_valid && ready;
        first_acc = accept && (state_q == FILL) && (fill_q == 3'd0);

        state_d = state_q;
        fill_d  = fill_q;
        grp_d   = grp_q;
        pad_d   = pad_q;
        w_d     = w_q;
        emit    = 1'b0;

        case (state_q)
            FILL, RUN: begin
                if (accept) begin
                    w_d[3] = w_q[2];
                    w_d[2] = w_q[1];
                    w_d[1] = w_q[0];
                    w_d[0] = bus.s_data;
                    fill_d = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
                    grp_d  = grp_q + 2'd1;
                    emit   = (MODE_BLOCK != 0) ? (grp_q == 2'd3) : (fill_q >= 3'd3);
                    if (state_q == FILL && fill_q == 3'd3) begin
                        state_d = RUN;
                    end
                    if (bus.s_last) begin
                        pad_d = '0;
                        // A block-mode frame ending on a group boundary has nothing to pad
                        if (FLUSH_EN == 0 || (MODE_BLOCK != 0 && grp_d == 2'd0)) begin
                            state_d = DONE;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                w_d[3] = w_q[2];
                w_d[2] = w_q[1];
                w_d[1] = w_q[0];
                w_d[0] = '0;
                grp_d  = grp_q + 2'd1;
                pad_d  = pad_q + 2'd1;
                if (MODE_BLOCK != 0) begin
                    emit = (grp_q == 2'd3);
                    if (grp_q == 2'd3) begin
                        state_d = DONE;
                    end
                end else begin
                    emit = 1'b1;
                    if (pad_q == 2'd2) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                w_d     = '{default: '0};
                fill_d  = '0;
                grp_d   = '0;
                pad_d   = '0;
                state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            w_q     <= '{default: '0};
            fill_q  <= '0;
            grp_q   <= '0;
            pad_q   <= '0;
            out_q   <= '{default: '0};
            mu_sh_q <= MU_ONE;
            mu_q    <= MU_ONE;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            fill_q  <= fill_d;
            grp_q   <= grp_d;
            pad_q   <= pad_d;
            en_q    <= emit;
            done_q  <= (state_q == DONE);
            if (emit) begin
                out_q[0] <= w_d[3];
                out_q[1] <= w_d[2];
                out_q[2] <= w_d[1];
                out_q[3] <= w_d[0];
            end
            if (bus.mu_load) begin
                mu_sh_q <= bus.mu_cfg;
            end
            // mu is latched only on the first accept so it cannot move mid-frame
            if (first_acc) begin
                mu_q <= bus.mu_load ? bus.mu_cfg : mu_sh_q;
            end
        end
    end

    assign bus.s_ready    = ready;
    assign bus.data1_out  = out_q[0];
    assign bus.data2_out  = out_q[1];
    assign bus.data3_out  = out_q[2];
    assign bus.data4_out  = out_q[3];
    assign bus.mu_out     = mu_q;
    assign bus.enable_out = en_q;
    assign bus.frame_done = done_q;

endmodule
